button_conditioner: RTL and testbench

Front-end for the pet controller: conditions the raw board pushbuttons and tilt sensor into the clean single-cycle command pulses, the `giro` level, and the test-mode handshake (`botonTest`, `BpulseTest`) that the central state machine consumes. It sits between the FPGA pins and the central FSM. It is the only producer of those signals, and its outputs connect one-to-one to the FSM inputs of the same names.

---
 rtl/button_conditioner_pkg.sv | 20 ++
 rtl/button_conditioner_debounce.sv | 58 +++++
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton / tilt front-end.
//   ctrl_state_e  : control FSM encoding (NORMAL, TEST, EXIT)
//   BPULSE_MIN/MAX: legal range of the test-scenario selector
//   next_count    : selector increment that wraps 9 -> 1, never to 0
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_TEST   = 2'd1,
        ST_EXIT   = 2'd2
    } ctrl_state_e;

    localparam logic [3:0] BPULSE_MIN = 4'd1;
    localparam logic [3:0] BPULSE_MAX = 4'd9;

    function automatic logic [3:0] next_count(input logic [3:0] c);
        return (c >= BPULSE_MAX) ? BPULSE_MIN : c + 4'd1;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// debounce: 2-FF synchronizer followed by a stable-count debouncer.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   raw_i   : raw asynchronous input pin
//   level_o : debounced level, active-high (inverted after sync when INVERT=1)
// The debounced level changes only after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          synced;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Synchronizer flops reset to the idle pin level so a released
    // active-low button does not look pressed straight after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= INVERT;
            sync2_q <= INVERT;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign synced = sync2_q ^ INVERT;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions raw pushbuttons and tilt sensor into the
// command pulses, tilt level and test-mode handshake for the central FSM.
//   clk, rst                      : clock, asynchronous active-high reset
//   btn_{sleep,awake,feed,play,test}_n : raw active-low pushbuttons
//   giro_raw                      : raw active-high tilt sensor
//   botonSleep/Awake/Feed/Play    : single-cycle press pulses (NORMAL only)
//   giro                          : debounced tilt level
//   botonTest                     : high for the whole of test mode
//   BpulseTest                    : test-scenario selector, 0 or 1..9
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 250000000,
    parameter int unsigned EXIT_HOLD         = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep_n,
    input  logic       btn_awake_n,
    input  logic       btn_feed_n,
    input  logic       btn_play_n,
    input  logic       btn_test_n,
    input  logic       giro_raw,
    output logic       botonSleep,
    output logic       botonAwake,
    output logic       botonFeed,
    output logic       botonPlay,
    output logic       giro,
    output logic       botonTest,
    output logic [3:0] BpulseTest
);

    localparam int unsigned LW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int unsigned EW = (EXIT_HOLD > 1) ? $clog2(EXIT_HOLD) : 1;
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [EW-1:0] EXIT_LAST = EW'(EXIT_HOLD - 1);

    // Bit order of the button vectors: {test, play, feed, awake, sleep}
    logic [4:0] btn_lvl;
    logic [4:0] btn_prev_q;
    logic [4:0] btn_edge_q;
    logic       giro_lvl;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_db_sleep (
        .clk_i(clk), .rst_i(rst), .raw_i(btn_sleep_n), .level_o(btn_lvl[0]));
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_db_awake (
        .clk_i(clk), .rst_i(rst), .raw_i(btn_awake_n), .level_o(btn_lvl[1]));
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_db_feed (
        .clk_i(clk), .rst_i(rst), .raw_i(btn_feed_n), .level_o(btn_lvl[2]));
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_db_play (
        .clk_i(clk), .rst_i(rst), .raw_i(btn_play_n), .level_o(btn_lvl[3]));
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b1)) u_db_test (
        .clk_i(clk), .rst_i(rst), .raw_i(btn_test_n), .level_o(btn_lvl[4]));
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INVERT(1'b0)) u_db_giro (
        .clk_i(clk), .rst_i(rst), .raw_i(giro_raw), .level_o(giro_lvl));

    ctrl_state_e   state_q, state_d;
    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic [EW-1:0] exit_cnt_q, exit_cnt_d;
    logic [3:0]    count_q, count_d;
    logic          wait_rel_q, wait_rel_d;
    logic [3:0]    cmd_q, cmd_d;        // {play, feed, awake, sleep}
    logic          test_q, test_d;
    logic [3:0]    bpulse_q, bpulse_d;
    logic          giro_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            state_q    <= ST_NORMAL;
            long_cnt_q <= '0;
            exit_cnt_q <= '0;
            count_q    <= '0;
            wait_rel_q <= 1'b0;
            cmd_q      <= '0;
            test_q     <= 1'b0;
            bpulse_q   <= '0;
            giro_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_lvl;
            btn_edge_q <= btn_lvl & ~btn_prev_q;
            state_q    <= state_d;
            long_cnt_q <= long_cnt_d;
            exit_cnt_q <= exit_cnt_d;
            count_q    <= count_d;
            wait_rel_q <= wait_rel_d;
            cmd_q      <= cmd_d;
            test_q     <= test_d;
            bpulse_q   <= bpulse_d;
            giro_q     <= giro_lvl;
        end
    end

    always_comb begin
        state_d    = state_q;
        long_cnt_d = '0;
        exit_cnt_d = '0;
        count_d    = count_q;
        // A low debounced test level always releases the re-arm lock;
        // the state branches below may set it again.
        wait_rel_d = wait_rel_q & btn_lvl[4];
        cmd_d      = '0;

        unique case (state_q)
            ST_NORMAL: begin
                cmd_d = btn_edge_q[3:0];
                if (btn_lvl[4] && !wait_rel_q) begin
                    if (long_cnt_q == LONG_LAST) begin
                        state_d    = ST_TEST;
                        // The press that got us here must be released
                        // before a test pulse can request exit.
                        wait_rel_d = 1'b1;
                    end else begin
                        long_cnt_d = long_cnt_q + LW'(1);
                    end
                end
            end
            ST_TEST: begin
                if (btn_edge_q[3]) begin
                    count_d = next_count(count_q);
                end
                if (btn_edge_q[4] && !wait_rel_q && (count_q != '0)) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                wait_rel_d = 1'b1;
                if (exit_cnt_q == EXIT_LAST) begin
                    state_d = ST_NORMAL;
                    count_d = '0;
                end else begin
                    exit_cnt_d = exit_cnt_q + EW'(1);
                end
            end
            default: begin
                state_d = ST_NORMAL;
                count_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state transition.
        test_d   = (state_d == ST_TEST);
        bpulse_d = (state_d == ST_NORMAL) ? 4'd0 : count_d;
    end

    assign botonSleep = cmd_q[0];
    assign botonAwake = cmd_q[1];
    assign botonFeed  = cmd_q[2];
    assign botonPlay  = cmd_q[3];
    assign giro       = giro_q;
    assign botonTest  = test_q;
    assign BpulseTest = bpulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 20;
    localparam int unsigned EH = 2;

    localparam logic [3:0] C_NONE  = 4'b0000;
    localparam logic [3:0] C_SLEEP = 4'b1000;
    localparam logic [3:0] C_AWAKE = 4'b0100;
    localparam logic [3:0] C_FEED  = 4'b0010;
    localparam logic [3:0] C_PLAY  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_sleep_n = 1'b1;
    logic       btn_awake_n = 1'b1;
    logic       btn_feed_n  = 1'b1;
    logic       btn_play_n  = 1'b1;
    logic       btn_test_n  = 1'b1;
    logic       giro_raw    = 1'b0;
    logic       botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest;
    logic [3:0] BpulseTest;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_PRESS_CYCLES(LP),
        .EXIT_HOLD(EH)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_sleep_n(btn_sleep_n), .btn_awake_n(btn_awake_n),
        .btn_feed_n(btn_feed_n), .btn_play_n(btn_play_n),
        .btn_test_n(btn_test_n), .giro_raw(giro_raw),
        .botonSleep(botonSleep), .botonAwake(botonAwake),
        .botonFeed(botonFeed), .botonPlay(botonPlay),
        .giro(giro), .botonTest(botonTest), .BpulseTest(BpulseTest)
    );

    // Observed output vector: {sleep, awake, feed, play, giro, botonTest, BpulseTest}
    logic [9:0] obs;
    assign obs = {botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest, BpulseTest};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    function automatic logic [9:0] mk(input logic [3:0] cmd, input logic g,
                                      input logic t, input logic [3:0] bp);
        return {cmd, g, t, bp};
    endfunction

    task automatic push_exp(input int c, input logic [9:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        expq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output vector must match the next
    // expected change, both in value and in the cycle it appears.
    initial begin
        logic [9:0] prev_vec;
        exp_t       e;
        prev_vec = '0;
        forever begin
            @(negedge clk);
            if (mon_en && (obs !== prev_vec)) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=%b (no change)",
                             cyc, obs, prev_vec);
                end else begin
                    e = expq.pop_front();
                    if ((e.cyc != cyc) || (e.vec !== obs)) begin
                        n_fail++;
                        $display("FAIL out_change got cyc=%0d vec=%b required cyc=%0d vec=%b",
                                 cyc, obs, e.cyc, e.vec);
                    end
                end
                prev_vec = obs;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;

        tick(3);
        rst = 1'b0;
        tick(2);
        n_tests++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%b required=%b", obs, 10'd0);
        end
        mon_en = 1'b1;

        // Tilt level rises then falls: visible DB+3 cycles after the pin change
        giro_raw = 1'b1; s = cyc;
        push_exp(s + 7, mk(C_NONE, 1'b1, 1'b0, 4'd0));
        tick(12);
        giro_raw = 1'b0; s = cyc;
        push_exp(s + 7, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        tick(12);

        // Bounce on feed (2-cycle runs), then a stable low
        for (int i = 0; i < 5; i++) begin
            btn_feed_n = 1'b0; tick(2);
            btn_feed_n = 1'b1; tick(2);
        end
        btn_feed_n = 1'b0; s = cyc;
        push_exp(s + 8, mk(C_FEED, 1'b0, 1'b0, 4'd0));
        push_exp(s + 9, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        tick(20);
        btn_feed_n = 1'b1;
        tick(12);

        // Simultaneous sleep and awake presses forwarded in the same cycle
        btn_sleep_n = 1'b0; btn_awake_n = 1'b0; s = cyc;
        push_exp(s + 8, mk(C_SLEEP | C_AWAKE, 1'b0, 1'b0, 4'd0));
        push_exp(s + 9, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        tick(10);
        btn_sleep_n = 1'b1; btn_awake_n = 1'b1;
        tick(12);

        // Long hold on play: exactly one pulse, nothing on release
        btn_play_n = 1'b0; s = cyc;
        push_exp(s + 8, mk(C_PLAY, 1'b0, 1'b0, 4'd0));
        push_exp(s + 9, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        tick(100);
        btn_play_n = 1'b1;
        tick(20);

        // Short test press: no output at all
        btn_test_n = 1'b0; tick(10);
        btn_test_n = 1'b1; tick(30);

        // Test entry: debounced at s+6, botonTest LP cycles later
        btn_test_n = 1'b0; s = cyc;
        push_exp(s + 26, mk(C_NONE, 1'b0, 1'b1, 4'd0));
        tick(30);
        btn_test_n = 1'b1;
        tick(12);

        // Feed press in TEST is discarded
        btn_feed_n = 1'b0; tick(8);
        btn_feed_n = 1'b1; tick(12);

        // 11 play presses: 1..9,1,2 then a 12th giving 3; botonPlay stays 0
        for (int i = 0; i < 12; i++) begin
            btn_play_n = 1'b0; s = cyc;
            push_exp(s + 8, mk(C_NONE, 1'b0, 1'b1, 4'((i % 9) + 1)));
            tick(6);
            btn_play_n = 1'b1;
            tick(10);
        end

        // Exit with count=3, button held 30+ cycles afterwards
        btn_test_n = 1'b0; s = cyc;
        push_exp(s + 8, mk(C_NONE, 1'b0, 1'b0, 4'd3));
        push_exp(s + 10, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        tick(40);
        btn_test_n = 1'b1;
        tick(15);

        // Re-enter TEST (count restarts at 0)
        btn_test_n = 1'b0; s = cyc;
        push_exp(s + 26, mk(C_NONE, 1'b0, 1'b1, 4'd0));
        tick(30);
        btn_test_n = 1'b1;
        tick(12);

        // Test press with count=0 is ignored
        btn_test_n = 1'b0; tick(8);
        btn_test_n = 1'b1; tick(20);

        // Asynchronous reset drops everything within the cycle
        s = cyc;
        push_exp(s, mk(C_NONE, 1'b0, 1'b0, 4'd0));
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL rst_async got=%b required=%b", obs, 10'd0);
        end
        tick(3);
        rst = 1'b0;
        tick(10);

        while (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL missing_change got=none required cyc=%0d vec=%b", e.cyc, e.vec);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
